// File: rtl/inst_sequencer_if.sv
// inst_sequencer_if: control, fetch, data-memory and MAC handshake bundle of the sequencer
//   master (sequencer): drives imem_req/imem_addr, inst, dmem_req/dmem_we, rf_we,
//                       mac_start, pc, busy, err; receives start, stop and the acks/rdata
//   slave (environment): the mirror image
interface inst_sequencer_if #(
    parameter int ISA_WIDTH = 16,
    parameter int PC_WIDTH  = 8
);
    logic                 start;
    logic                 stop;
    logic                 imem_req;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic                 imem_ack;
    logic [ISA_WIDTH-1:0] imem_rdata;
    logic [ISA_WIDTH-1:0] inst;
    logic                 dmem_req;
    logic                 dmem_we;
    logic                 dmem_ack;
    logic                 rf_we;
    logic                 mac_start;
    logic                 mac_done;
    logic [PC_WIDTH-1:0]  pc;
    logic                 busy;
    logic                 err;
    modport master (
        input  start, stop, imem_ack, imem_rdata, dmem_ack, mac_done,
        output imem_req, imem_addr, inst, dmem_req, dmem_we, rf_we, mac_start, pc, busy, err
    );
    modport slave (
        output start, stop, imem_ack, imem_rdata, dmem_ack, mac_done,
        input  imem_req, imem_addr, inst, dmem_req, dmem_we, rf_we, mac_start, pc, busy, err
    );
endinterface

// File: rtl/inst_sequencer.sv
// inst_sequencer: fetch/decode/execute sequencer for LOAD, STORE, MOV and MAC instructions
//   clk, rst : single clock, synchronous active-high reset
//   bus      : inst_sequencer_if master port (start/stop control, instruction fetch,
//              data memory, register-file strobe, MAC handshake, pc/busy/err status)
module inst_sequencer #(
    parameter int ISA_WIDTH   = 16,
    parameter int PC_WIDTH    = 8,
    parameter int MAC_TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst,
    inst_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, MACW, WB, ERR} state_t;
    state_t               state, state_nx;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [ISA_WIDTH-1:0] inst_q;
    logic [3:0]           cnt;
    logic                 stop_q;
    logic [2:0]           op;
    logic                 busy;
    logic                 retire;
    logic                 stop_any;
    logic                 mac_to;
    assign op       = inst_q[ISA_WIDTH-1 -: 3];
    assign busy     = state != IDLE && state != ERR;
    // a stop arriving in the retire cycle itself still counts
    assign stop_any = stop_q | bus.stop;
    // cnt is 0 in the first MACW cycle, so this marks the last permitted wait cycle
    assign mac_to   = cnt == 4'(MAC_TIMEOUT - 1);
    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        case (state)
            IDLE:    state_nx = bus.start ? FETCH : IDLE;
            FETCH:   state_nx = bus.imem_ack ? DECODE : FETCH;
            DECODE:  state_nx = (op == 3'b000 || op == 3'b001) ? MEM :
                                op == 3'b010 ? WB : op == 3'b100 ? MACW : ERR;
            MEM: begin
                retire   = bus.dmem_ack && op == 3'b001;
                state_nx = (bus.dmem_ack && op == 3'b000) ? WB : MEM;
            end
            // mac_done takes priority over a simultaneous timeout
            MACW:    state_nx = bus.mac_done ? WB : mac_to ? ERR : MACW;
            WB:      retire = 1'b1;
            ERR:     state_nx = ERR;
            default: state_nx = IDLE;
        endcase
        if (retire)
            state_nx = stop_any ? IDLE : FETCH;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= '0;
            inst_q <= '0;
            cnt    <= '0;
            stop_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start)
                pc_q <= '0;
            else if (retire)
                pc_q <= pc_q + 1'b1;
            if (state == FETCH && bus.imem_ack)
                inst_q <= bus.imem_rdata;
            // held at zero outside MACW, so it is clear on every MACW entry
            cnt    <= state == MACW ? cnt + 4'd1 : 4'd0;
            stop_q <= busy && stop_any && !retire;
        end
    end
    assign bus.imem_req  = state == FETCH;
    assign bus.imem_addr = pc_q;
    assign bus.inst      = inst_q;
    assign bus.dmem_req  = state == MEM;
    assign bus.dmem_we   = state == MEM && op == 3'b001;
    assign bus.rf_we     = state == WB;
    assign bus.mac_start = state == MACW && cnt == 4'd0;
    assign bus.pc        = pc_q;
    assign bus.busy      = busy;
    assign bus.err       = state == ERR;
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: randomized transaction-level check of inst_sequencer
module tb_inst_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    inst_sequencer_if #(.ISA_WIDTH(16), .PC_WIDTH(8)) bus ();
    inst_sequencer #(.ISA_WIDTH(16), .PC_WIDTH(8), .MAC_TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mpc      = 8'd0;
    bit         e, s;
    logic [2:0] ops [4]  = '{3'b000, 3'b001, 3'b010, 3'b100};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic idle_in();
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0;
        bus.dmem_ack   = 1'b0;
        bus.mac_done   = 1'b0;
    endtask
    task automatic outs_zero(input string tag);
        chk(tag, {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.mac_start,
                  bus.busy, bus.err, bus.pc, bus.inst}, 32'h0);
    endtask
    // noisy: every other input is asserted alongside rst, which must win
    task automatic do_reset(input string tag, input bit noisy);
        rst = 1'b1;
        if (noisy) begin
            bus.start = 1'b1; bus.stop = 1'b1; bus.imem_ack = 1'b1;
            bus.dmem_ack = 1'b1; bus.mac_done = 1'b1;
        end else
            idle_in();
        @(negedge clk);
        idle_in();
        rst = 1'b0;
        mpc = 8'd0;
        outs_zero(tag);
    endtask
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        mpc = 8'd0;
        chk("start", {bus.busy, bus.imem_req, bus.pc}, {1'b1, 1'b1, 8'd0});
    endtask
    // Runs one instruction from FETCH; fd/md/cd are ack delays (cd >= 15 means no mac_done)
    task automatic exec(input logic [15:0] ins, input int fd, input int md, input int cd,
                        input bit stop_en, output bit errx, output bit stopped);
        int  cyc = 0, fc = 0, dc = 0, mc = 0, rf = 0, ms = 0, dr = 0, dw = 0, cexp, sc;
        bit  left = 0, seen = 0, done = 0;
        logic [2:0] op = ins[15:13];
        bit  mem = op == 3'b000 || op == 3'b001;
        bit  legal = mem || op == 3'b010 || op == 3'b100;
        errx = !legal || (op == 3'b100 && cd >= 15);
        cexp = fd + 2 + (op == 3'b000 ? md + 2 : op == 3'b001 ? md + 1 : op == 3'b010 ? 1 :
                         op == 3'b100 ? (cd < 15 ? cd + 2 : 15) : 0);
        sc = $urandom_range(0, cexp - 1);
        stopped = stop_en && !errx;
        while (cyc < 100) begin
            if (!bus.busy || (bus.imem_req && left)) begin
                done = 1;
                break;
            end
            if (!bus.imem_req) left = 1;
            rf += int'(bus.rf_we);
            ms += int'(bus.mac_start);
            dr += int'(bus.dmem_req);
            dw += int'(bus.dmem_we);
            bus.imem_ack   = bus.imem_req && fc == fd;
            bus.imem_rdata = bus.imem_ack ? ins : 16'($urandom);
            if (bus.imem_req) fc++;
            bus.dmem_ack = bus.dmem_req && dc == md;
            if (bus.dmem_req) dc++;
            if (bus.mac_start) seen = 1;
            bus.mac_done = seen && mc == cd;
            if (seen) mc++;
            bus.stop  = stop_en && cyc == sc;
            bus.start = ($urandom % 8) == 0;
            cyc++;
            @(negedge clk);
        end
        idle_in();
        if (!errx) mpc = mpc + 8'd1;
        chk("bound", 32'(done), 32'd1);
        chk("cycles", cyc, cexp);
        chk("rf_we", rf, (op == 3'b000 || op == 3'b010 || (op == 3'b100 && cd < 15)) ? 1 : 0);
        chk("mac_start", ms, op == 3'b100 ? 1 : 0);
        chk("dmem_req", dr, mem ? md + 1 : 0);
        chk("dmem_we", dw, op == 3'b001 ? md + 1 : 0);
        chk("status", {bus.err, bus.busy, bus.imem_req},
            {errx, !errx && !stopped, !errx && !stopped});
        chk("pc", bus.pc, mpc);
        chk("inst", bus.inst, ins);
    endtask
    initial begin
        rst = 1'b1;
        idle_in();
        do_reset("reset", 1'b0);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("idle_stop", {bus.busy, bus.imem_req}, 2'b00);
        do_start();
        exec(16'h4A05, 0, 0, 0, 0, e, s);
        for (int i = 0; i < 300; i++) begin
            exec({ops[$urandom % 4], 13'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 14), mpc == 8'hFF, e, s);
            if (s) break;
        end
        chk("wrap_idle", {bus.busy, bus.pc}, 9'd0);
        do_start();
        exec(16'h2300, 0, 2, 0, 0, e, s);
        exec(16'h0123, 0, 0, 0, 0, e, s);
        exec(16'h8121, 0, 0, 20, 0, e, s);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_start", {bus.err, bus.busy, bus.imem_req, bus.pc}, {3'b100, mpc});
        do_reset("err_clear", 1'b0);
        do_start();
        exec(16'hE000, 1, 0, 0, 0, e, s);
        do_reset("illegal_clear", 1'b0);
        do_start();
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ins = ($urandom % 8 == 0) ? 16'($urandom) : {ops[$urandom % 4], 13'($urandom)};
            exec(ins, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 17),
                 ($urandom % 10) == 0, e, s);
            if (e) begin
                do_reset("rand_rst", $urandom % 2 == 1);
                do_start();
            end else if (s) begin
                if ($urandom % 2 == 1) begin
                    bus.stop = 1'b1;
                    @(negedge clk);
                    bus.stop = 1'b0;
                end
                do_start();
            end
        end
        do_reset("pre_mem", 1'b0);
        do_start();
        bus.imem_rdata = 16'h2300;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        idle_in();
        @(negedge clk);
        chk("in_mem", {bus.dmem_req, bus.dmem_we}, 2'b11);
        do_reset("rst_mem", 1'b1);
        @(negedge clk);
        outs_zero("post_rst_idle");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter ISA_WIDTH, default 16, SHALL set the instruction width.
REQ-002 Parameter PC_WIDTH, default 8, SHALL set the program counter width.
REQ-003 Parameter MAC_TIMEOUT, default 15, SHALL set the maximum number of cycles to wait for mac_done.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin execution at pc 0 (honoured in IDLE only).
REQ-007 stop  input  1  request return to IDLE at the next instruction boundary.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 imem_addr  output  PC_WIDTH  fetch address, equal to pc.
REQ-010 imem_ack  input  1  fetch data valid.
REQ-011 imem_rdata  input  ISA_WIDTH  fetched instruction.
REQ-012 inst  output  ISA_WIDTH  latched instruction, fed to the decoder.
REQ-013 dmem_req  output  1  data memory request.
REQ-014 dmem_we  output  1  data memory write (1 = STORE).
REQ-015 dmem_ack  input  1  data memory access complete.
REQ-016 rf_we  output  1  register file write strobe.
REQ-017 mac_start  output  1  single-cycle MAC launch pulse.
REQ-018 mac_done  input  1  MAC result ready.
REQ-019 pc  output  PC_WIDTH  current program counter.
REQ-020 busy  output  1  high in every state except IDLE and ERR.
REQ-021 err  output  1  sticky error flag (illegal opcode or MAC timeout).

Function
REQ-022 opcode SHALL be inst[ISA_WIDTH-1:ISA_WIDTH-3]: LOAD=000, STORE=001, MOV=010, MAC=100; all other codes are illegal.
REQ-023 The FSM SHALL have the states IDLE, FETCH, DECODE, MEM, MACW, WB and ERR.
REQ-024 In IDLE, start=1 SHALL set pc to 0 and go to FETCH; start in any other state SHALL be ignored.
REQ-025 In FETCH, imem_req SHALL be held at 1 until imem_ack=1 is sampled, including an ack in the first cycle of FETCH.
REQ-026 On that ack, inst SHALL load imem_rdata and the FSM SHALL go to DECODE.
REQ-027 DECODE SHALL last exactly 1 cycle and then go to MEM for LOAD or STORE, WB for MOV, MACW for MAC, and ERR for an illegal opcode.
REQ-028 In MEM, dmem_req SHALL be 1 and dmem_we SHALL be 1 only for STORE, both held until dmem_ack.
REQ-029 On dmem_ack, a LOAD SHALL go to WB and a STORE SHALL retire (no rf_we).
REQ-030 On entering MACW, mac_start SHALL be 1 for exactly its first cycle, and a 4-bit wait counter SHALL clear.
REQ-031 In MACW, mac_done SHALL go to WB.
REQ-032 In MACW, if the wait counter reaches MAC_TIMEOUT without mac_done, the FSM SHALL go to ERR.
REQ-033 If mac_done and the timeout occur in the same cycle, mac_done SHALL win.
REQ-034 WB SHALL assert rf_we for exactly 1 cycle and then retire the instruction.
REQ-035 Retire SHALL set pc to pc+1 modulo 2^PC_WIDTH (255 wraps to 0).
REQ-036 Retire SHALL then enter IDLE if a stop request is latched (clearing the latch), otherwise FETCH.
REQ-037 stop SHALL be latched in any busy cycle and SHALL be discarded in IDLE and ERR.
REQ-038 An in-flight instruction SHALL always complete before a stop takes effect.
REQ-039 ERR SHALL set err=1, deassert all request and strobe outputs, and be left only by rst.
REQ-040 Minimum latency with same-cycle acks SHALL be: MOV 3 cycles (FETCH, DECODE, WB); STORE 3; LOAD 4; MAC 4 plus the mac_done wait.
REQ-041 imem_req, dmem_req, dmem_we, rf_we and mac_start SHALL be registered or pure state decodes, free of combinational paths from any ack input.

Reset
REQ-042 rst=1 SHALL, at the next clock edge and from any state, force IDLE and clear the stop latch.
REQ-043 rst=1 SHALL, at the same edge, set pc=0, inst=0 and the wait counter to 0.
REQ-044 rst=1 SHALL, at the same edge, deassert all outputs, including err.
REQ-045 rst SHALL override start, stop and all acks in the same cycle.
REQ-046 Reset in the middle of an operation SHALL abandon outstanding memory or MAC requests without further strobes.

Verification
REQ-047 Scenario (MOV): start, then imem_rdata=0x4A05 with immediate ack -> rf_we pulses on cycle 3, pc becomes 1, FSM re-enters FETCH.
REQ-048 Scenario (STORE/LOAD): STORE 0x2300 with dmem_ack delayed 2 cycles -> dmem_we=1 held for 3 cycles and no rf_we; then LOAD 0x0123 -> rf_we pulses once after dmem_ack.
REQ-049 Scenario (MAC timeout): MAC 0x8121 with mac_done never asserted -> err=1 and busy=0 after 15 MACW cycles; a later start is ignored and rst clears err.
REQ-050 Scenario (illegal opcode): 0xE000 fetched -> ERR entered directly after DECODE, with no dmem_req, rf_we or mac_start.
REQ-051 Scenario (stop and wrap): pc=255 with stop pulsed during FETCH -> the instruction completes, pc wraps to 0, FSM enters IDLE and busy=0.
REQ-052 Scenario (reset in MEM): rst asserted while dmem_req=1 -> next cycle all outputs are 0, pc=0 and the FSM is in IDLE.
